// File: rtl/cordic_park_engine.sv
// Iterative CORDIC rotator for forward/inverse Park: one micro-rotation per clock, then gain/round/saturate.
// Accept on edge E -> out_valid after edge E+ITERATIONS+1; single request in flight, result held until out_ready.
module cordic_park_engine #(
  parameter int WIDTH       = 16,
  parameter int ANGLE_WIDTH = 16,
  parameter int ITERATIONS  = 14,
  parameter int GUARD_BITS  = 3,
  parameter int GAIN_BITS   = 15,
  parameter int TAG_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          mode,
  input  logic signed [WIDTH-1:0]       in_x,
  input  logic signed [WIDTH-1:0]       in_y,
  input  logic [ANGLE_WIDTH-1:0]        angle,
  input  logic [TAG_WIDTH-1:0]          in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [WIDTH-1:0]       out_x,
  output logic signed [WIDTH-1:0]       out_y,
  output logic [TAG_WIDTH-1:0]          out_tag,
  output logic                          busy
);

  localparam int XW = WIDTH + 2 + GUARD_BITS;
  localparam int ZW = ANGLE_WIDTH + 1;
  localparam int IW = $clog2(ITERATIONS + 1);
  localparam int SH = GAIN_BITS + GUARD_BITS;
  localparam int PW = XW + GAIN_BITS + 1;

  function automatic logic [ZW-1:0] atan_entry(input int i);
    real v;
    v = $atan(1.0 / (2.0 ** i)) / (2.0 * 3.14159265358979323846) * (2.0 ** ANGLE_WIDTH);
    return ZW'($rtoi(v + 0.5));
  endfunction

  function automatic int gain_k();
    real k;
    k = 1.0;
    for (int i = 0; i < ITERATIONS; i++) k = k / $sqrt(1.0 + 1.0 / (2.0 ** (2 * i)));
    return $rtoi(k * (2.0 ** GAIN_BITS) + 0.5);
  endfunction

  localparam int                     K_INT = gain_k();
  localparam logic signed [GAIN_BITS:0] K  = (GAIN_BITS + 1)'(K_INT);
  localparam logic signed [ZW-1:0]   P_Q   = ZW'(64'd1 << (ANGLE_WIDTH - 2));
  localparam logic signed [PW-1:0]   HALF  = PW'(64'd1 << (SH - 1));
  localparam logic signed [PW-1:0]   MAXV  = PW'((64'd1 << (WIDTH - 1)) - 64'd1);
  localparam logic signed [PW-1:0]   MINV  = -MAXV - PW'(1);

  logic [ZW-1:0] atan_tab [ITERATIONS];
  for (genvar g = 0; g < ITERATIONS; g++) begin : g_atan
    localparam logic [ZW-1:0] A = atan_entry(g);
    assign atan_tab[g] = A;
  end

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [PW-1:0] v);
    if (v > MAXV) return MAXV[WIDTH-1:0];
    if (v < MINV) return MINV[WIDTH-1:0];
    return v[WIDTH-1:0];
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_SCALE, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic signed [XW-1:0]     x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0]     z_q, z_d;
  logic [IW-1:0]            iter_q, iter_d;
  logic [TAG_WIDTH-1:0]     tag_q, tag_d, out_tag_q, out_tag_d;
  logic signed [WIDTH-1:0]  out_x_q, out_x_d, out_y_q, out_y_d;

  // Quadrant pre-rotation folds |phi| into the CORDIC convergence range.
  logic signed [ANGLE_WIDTH-1:0] phi;
  logic signed [ZW-1:0]          phi_ext, z0;
  logic signed [XW-1:0]          xin, yin, x0, y0;

  always_comb begin
    phi     = mode ? $signed(angle) : $signed(-angle);
    phi_ext = ZW'(phi);
    xin     = XW'(in_x) <<< GUARD_BITS;
    yin     = XW'(in_y) <<< GUARD_BITS;
    x0      = xin;
    y0      = yin;
    z0      = phi_ext;
    if (phi_ext >= P_Q) begin
      x0 = -yin;
      y0 = xin;
      z0 = phi_ext - P_Q;
    end else if (phi_ext < -P_Q) begin
      x0 = yin;
      y0 = -xin;
      z0 = phi_ext + P_Q;
    end
  end

  logic signed [XW-1:0] xs, ys;
  logic signed [ZW-1:0] atan_i;
  logic                 dir_pos;
  logic signed [PW-1:0] px, py, rx, ry;

  always_comb begin
    xs      = x_q >>> iter_q;
    ys      = y_q >>> iter_q;
    atan_i  = $signed(atan_tab[iter_q]);
    dir_pos = ~z_q[ZW-1];
    px      = PW'(x_q) * PW'(K);
    py      = PW'(y_q) * PW'(K);
    rx      = (px + HALF) >>> SH;
    ry      = (py + HALF) >>> SH;
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    iter_d    = iter_q;
    tag_d     = tag_q;
    out_x_d   = out_x_q;
    out_y_d   = out_y_q;
    out_tag_d = out_tag_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          state_d = S_ROTATE;
          x_d     = x0;
          y_d     = y0;
          z_d     = z0;
          iter_d  = '0;
          tag_d   = in_tag;
        end
      end
      S_ROTATE: begin
        x_d = dir_pos ? x_q - ys : x_q + ys;
        y_d = dir_pos ? y_q + xs : y_q - xs;
        z_d = dir_pos ? z_q - atan_i : z_q + atan_i;
        if (iter_q == IW'(ITERATIONS - 1)) state_d = S_SCALE;
        else iter_d = iter_q + IW'(1);
      end
      S_SCALE: begin
        out_x_d   = sat(rx);
        out_y_d   = sat(ry);
        out_tag_d = tag_q;
        state_d   = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      iter_q    <= '0;
      tag_q     <= '0;
      out_x_q   <= '0;
      out_y_q   <= '0;
      out_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      iter_q    <= iter_d;
      tag_q     <= tag_d;
      out_x_q   <= out_x_d;
      out_y_q   <= out_y_d;
      out_tag_q <= out_tag_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_cordic_park_engine.sv
// Directed bench for cordic_park_engine: reset, Park directions, pre-rotation, saturation, backpressure, abort.
module tb_cordic_park_engine;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               mode = 1'b0;
  logic signed [15:0] in_x = '0;
  logic signed [15:0] in_y = '0;
  logic [15:0]        angle = '0;
  logic [1:0]         in_tag = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [15:0] out_x;
  logic signed [15:0] out_y;
  logic [1:0]         out_tag;
  logic               busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cordic_park_engine dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .in_x(in_x), .in_y(in_y), .angle(angle), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_tag(out_tag), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and returns 1ns after its accept edge.
  task automatic send(input bit m, input logic signed [15:0] x, input logic signed [15:0] y,
                      input logic [15:0] a, input logic [1:0] t, output bit to);
    mode = m; in_x = x; in_y = y; angle = a; in_tag = t; in_valid = 1'b1;
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) begin
        to = 1'b0;
        break;
      end
      step();
    end
    if (!to) step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit to);
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        to = 1'b0;
        break;
      end
      step();
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    step(); step();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (out_x !== 16'sd0) begin fails++; $display("FAIL reset_out_x: got %0d want 0", out_x); end
    tests++; if (out_y !== 16'sd0) begin fails++; $display("FAIL reset_out_y: got %0d want 0", out_y); end
    tests++; if (out_tag !== 2'd0) begin fails++; $display("FAIL reset_out_tag: got %0d want 0", out_tag); end
    rst = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_inverse_latency();
    bit to;
    int d;
    send(1'b1, 16'sd10000, 16'sd0, 16'h0000, 2'd1, to);
    tests++; if (to) begin fails++; $display("FAIL inv0_accept: got timeout want accept"); end
    for (int i = 0; i < 14; i++) step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL inv0_early_valid: got %b want 0", out_valid); end
    step();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL inv0_latency: got %b want 1", out_valid); end
    d = int'(out_x) - 10000;
    tests++; if (d > 4 || d < -4) begin fails++; $display("FAIL inv0_x: got %0d want 10000+-4", out_x); end
    d = int'(out_y);
    tests++; if (d > 4 || d < -4) begin fails++; $display("FAIL inv0_y: got %0d want 0+-4", out_y); end
    tests++; if (out_tag !== 2'd1) begin fails++; $display("FAIL inv0_tag: got %0d want 1", out_tag); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL inv0_busy: got %b want 1", busy); end
    handshake();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL inv0_after_hs_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_forward();
    bit to;
    int d;
    send(1'b0, 16'sd0, 16'sd10000, 16'h4000, 2'd3, to);
    wait_out(to);
    tests++; if (to) begin fails++; $display("FAIL fwd_timeout: got timeout want out_valid"); end
    d = int'(out_x) - 10000;
    tests++; if (d > 4 || d < -4) begin fails++; $display("FAIL fwd_d: got %0d want 10000+-4", out_x); end
    d = int'(out_y);
    tests++; if (d > 4 || d < -4) begin fails++; $display("FAIL fwd_q: got %0d want 0+-4", out_y); end
    tests++; if (out_tag !== 2'd3) begin fails++; $display("FAIL fwd_tag: got %0d want 3", out_tag); end
    handshake();
    // theta = -pi exercises the negative pre-rotation branch after wrapping negation
    send(1'b0, 16'sd10000, 16'sd0, 16'h8000, 2'd0, to);
    wait_out(to);
    tests++; if (to) begin fails++; $display("FAIL fwd_pi_timeout: got timeout want out_valid"); end
    d = int'(out_x) + 10000;
    tests++; if (d > 4 || d < -4) begin fails++; $display("FAIL fwd_pi_d: got %0d want -10000+-4", out_x); end
    d = int'(out_y);
    tests++; if (d > 4 || d < -4) begin fails++; $display("FAIL fwd_pi_q: got %0d want 0+-4", out_y); end
    handshake();
  endtask

  task automatic test_prerotation();
    bit to;
    int d;
    send(1'b1, 16'sd10000, 16'sd0, 16'hA000, 2'd2, to);
    wait_out(to);
    tests++; if (to) begin fails++; $display("FAIL prerot_timeout: got timeout want out_valid"); end
    d = int'(out_x) + 7071;
    tests++; if (d > 4 || d < -4) begin fails++; $display("FAIL prerot_x: got %0d want -7071+-4", out_x); end
    d = int'(out_y) + 7071;
    tests++; if (d > 4 || d < -4) begin fails++; $display("FAIL prerot_y: got %0d want -7071+-4", out_y); end
    tests++; if (out_tag !== 2'd2) begin fails++; $display("FAIL prerot_tag: got %0d want 2", out_tag); end
    handshake();
  endtask

  task automatic test_saturation();
    bit to;
    int d;
    send(1'b1, 16'sd32767, 16'sd32767, 16'h2000, 2'd1, to);
    wait_out(to);
    tests++; if (to) begin fails++; $display("FAIL sat_timeout: got timeout want out_valid"); end
    d = int'(out_x);
    tests++; if (d > 4 || d < -4) begin fails++; $display("FAIL sat_x: got %0d want 0+-4", out_x); end
    tests++; if (out_y !== 16'sd32767) begin fails++; $display("FAIL sat_y: got %0d want 32767", out_y); end
    handshake();
  endtask

  task automatic test_backpressure();
    bit to;
    int d;
    send(1'b1, 16'sd1000, 16'sd0, 16'h0000, 2'd1, to);
    wait_out(to);
    tests++; if (to) begin fails++; $display("FAIL bp_first_timeout: got timeout want out_valid"); end
    mode = 1'b1; in_x = 16'sd2000; in_y = 16'sd0; angle = 16'h0000; in_tag = 2'd2; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid: cycle %0d got %b want 1", c, out_valid); end
      tests++; if (out_tag !== 2'd1) begin fails++; $display("FAIL bp_hold_tag: cycle %0d got %0d want 1", c, out_tag); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_hold_in_ready: cycle %0d got %b want 0", c, in_ready); end
      d = int'(out_x) - 1000;
      tests++; if (d > 4 || d < -4) begin fails++; $display("FAIL bp_hold_x: cycle %0d got %0d want 1000+-4", c, out_x); end
      step();
    end
    handshake();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_hs_valid: got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_hs_in_ready: got %b want 1", in_ready); end
    tests++; if (out_tag !== 2'd1) begin fails++; $display("FAIL bp_tag_retained: got %0d want 1", out_tag); end
    step();
    in_valid = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL bp_second_accept: busy got %b want 1", busy); end
    wait_out(to);
    tests++; if (to) begin fails++; $display("FAIL bp_second_timeout: got timeout want out_valid"); end
    tests++; if (out_tag !== 2'd2) begin fails++; $display("FAIL bp_second_tag: got %0d want 2", out_tag); end
    d = int'(out_x) - 2000;
    tests++; if (d > 4 || d < -4) begin fails++; $display("FAIL bp_second_x: got %0d want 2000+-4", out_x); end
    handshake();
  endtask

  task automatic test_reset_abort();
    bit to;
    int seen;
    int d;
    send(1'b1, 16'sd7000, 16'sd0, 16'h0000, 2'd3, to);
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL abort_in_ready_during: got %b want 0", in_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", busy); end
    step();
    rst = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL abort_in_ready_after: got %b want 1", in_ready); end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen++;
      step();
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL abort_no_result: got %0d valid cycles want 0", seen); end
    send(1'b1, 16'sd5000, 16'sd0, 16'h0000, 2'd1, to);
    wait_out(to);
    tests++; if (to) begin fails++; $display("FAIL abort_new_timeout: got timeout want out_valid"); end
    d = int'(out_x) - 5000;
    tests++; if (d > 4 || d < -4) begin fails++; $display("FAIL abort_new_x: got %0d want 5000+-4", out_x); end
    tests++; if (out_tag !== 2'd1) begin fails++; $display("FAIL abort_new_tag: got %0d want 1", out_tag); end
    handshake();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_inverse_latency();
    test_forward();
    test_prerotation();
    test_saturation();
    test_backpressure();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
